// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue: buffers golden nonces in a small FIFO and feeds them one word at a
// time into serial_transmit through its send/busy/word handshake.
// Ports:
//   clk_i, reset_i          comm clock, asynchronous active-high reset
//   nonce_valid_i, nonce_in_i  golden nonce strobe and raw nonce
//   flush_i                 new-work strobe, discards queued untransmitted nonces
//   tx_busy_i               busy from serial_transmit
//   tx_send_o, tx_word_o    one-cycle send request and the word being transmitted
//   level_o                 FIFO occupancy, 0..DEPTH
//   overflow_o              sticky, a nonce was dropped on a full FIFO
// Optional GOLDEN_NONCE_DEDUP_EN: a nonce equal to the last accepted one is discarded.
module golden_nonce_queue #(
   parameter int          DEPTH        = 8,
   parameter logic [31:0] NONCE_OFFSET = 32'd0,
   parameter int          ARM_TIMEOUT  = 4
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   nonce_valid_i,
   input  logic [31:0]            nonce_in_i,
   input  logic                   flush_i,
   input  logic                   tx_busy_i,
   output logic                   tx_send_o,
   output logic [31:0]            tx_word_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   overflow_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(ARM_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, LOAD, SEND, ARM, DRAIN} state_t;
   state_t        state_q;
   logic [31:0]   mem_q [DEPTH];
   logic [AW:0]   wr_q, rd_q, wr_d, rd_d;
   logic [CW-1:0] tmo_q;
   logic [31:0]   tx_word_q, adj;
   logic          tx_send_q, overflow_q, full, empty, pop, dup, push;
`ifdef GOLDEN_NONCE_DEDUP_EN
   logic [31:0]   last_q;
   logic          last_v_q;
`endif
   always_comb begin
      adj   = nonce_in_i - NONCE_OFFSET;
      pop   = state_q == LOAD;
      empty = wr_q == rd_q;
      full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
`ifdef GOLDEN_NONCE_DEDUP_EN
      // flush invalidates last_nonce before the same-cycle write is judged
      dup   = last_v_q && !flush_i && (last_q == adj);
`else
      dup   = 1'b0;
`endif
      // a pop or flush in this cycle frees room for the incoming nonce
      push  = nonce_valid_i && !dup && (!full || pop || flush_i);
      rd_d  = flush_i ? wr_q : rd_q + (AW+1)'(pop);
      wr_d  = wr_q + (AW+1)'(push);
   end
   assign level_o    = wr_q - rd_q;
   assign tx_send_o  = tx_send_q;
   assign tx_word_o  = tx_word_q;
   assign overflow_o = overflow_q;
   always_ff @(posedge clk_i)
      if (push) mem_q[wr_q[AW-1:0]] <= adj;
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_q       <= '0;
         rd_q       <= '0;
         overflow_q <= 1'b0;
         state_q    <= IDLE;
         tx_send_q  <= 1'b0;
         tx_word_q  <= '0;
         tmo_q      <= '0;
`ifdef GOLDEN_NONCE_DEDUP_EN
         last_q     <= '0;
         last_v_q   <= 1'b0;
`endif
      end else begin
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         overflow_q <= overflow_q | (nonce_valid_i && !dup && !push);
         tx_send_q  <= 1'b0;
`ifdef GOLDEN_NONCE_DEDUP_EN
         if (flush_i) last_v_q <= 1'b0;
         if (push) begin
            last_q   <= adj;
            last_v_q <= 1'b1;
         end
`endif
         case (state_q)
            // a flush in this cycle empties the FIFO, so do not start a load
            IDLE:  if (!empty && !tx_busy_i && !flush_i) state_q <= LOAD;
            LOAD: begin
               tx_word_q <= mem_q[rd_q[AW-1:0]];
               tx_send_q <= 1'b1;
               state_q   <= SEND;
            end
            SEND: begin
               tmo_q   <= '0;
               state_q <= ARM;
            end
            // the word is abandoned, not re-queued, if the transmitter never answers
            ARM:   if (tx_busy_i) state_q <= DRAIN;
                   else if (tmo_q == CW'(ARM_TIMEOUT - 1)) state_q <= IDLE;
                   else tmo_q <= tmo_q + CW'(1);
            DRAIN: if (!tx_busy_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
